// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq
// Iterative AES key schedule generator for AES-128/192/256, selectable per key.
// A key is accepted on i_key_valid && o_key_ready. The generator then produces one
// 32-bit schedule word per cycle through a single SubWord instance and stores it in a
// 4*(MAX_NR+1)-word buffer. Cipher cores read complete round keys through a
// random-access port, in forward or reverse order. Reads may start during generation
// for rounds that are already complete.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_key_valid    key / key length valid
//   o_key_ready    block can accept a key (high in IDLE)
//   i_key          key word i = i_key[32*i +: 32]; words >= Nk are ignored
//   i_key_len      00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   o_cfg_err      one-cycle pulse after an illegal or unsupported key length was accepted
//   o_busy         schedule generation in progress
//   o_sched_valid  full schedule of the current key is available
//   o_round_avail  number of complete round keys that can be read
//   i_rd_en        read request
//   i_rd_round     round index to read
//   o_rd_valid     o_rd_key / o_rd_err valid, one cycle after i_rd_en
//   o_rd_key       {w[4r+3], w[4r+2], w[4r+1], w[4r]}
//   o_rd_err       read rejected (round not yet available); o_rd_key is zero
module aes_key_sched_seq #(
    parameter int MAX_NK = 8,
    parameter int MAX_NR = MAX_NK + 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_key_valid,
    output logic                  o_key_ready,
    input  logic [32*MAX_NK-1:0]  i_key,
    input  logic [1:0]            i_key_len,
    output logic                  o_cfg_err,
    output logic                  o_busy,
    output logic                  o_sched_valid,
    output logic [3:0]            o_round_avail,
    input  logic                  i_rd_en,
    input  logic [3:0]            i_rd_round,
    output logic                  o_rd_valid,
    output logic [127:0]          o_rd_key,
    output logic                  o_rd_err
);

    localparam int         DEPTH    = 4 * (MAX_NR + 1);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    // AES S-box, entry b at index b
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic {IDLE, GEN} state_t;

    state_t           r_state;
    logic [31:0]      r_w [DEPTH];
    logic [3:0]       r_nk;
    logic [3:0]       r_pos;
    logic [3:0]       r_rconIdx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_lastIdx;

    logic [3:0]       w_loadNk;
    logic             w_lenOk;
    logic             w_accept;
    logic             w_load;
    logic             w_genWrite;
    logic [31:0]      w_prev;
    logic [31:0]      w_back;
    logic [31:0]      w_subIn;
    logic [31:0]      w_subOut;
    logic [31:0]      w_newWord;

    // Decode the requested key length and decide whether this accept starts a
    // schedule. Writes are suppressed while reset is asserted so a reset cycle
    // never disturbs the buffer.
    always_comb begin
        w_loadNk = 4'd0;
        case (i_key_len)
            2'b00:   w_loadNk = 4'd4;
            2'b01:   w_loadNk = 4'd6;
            2'b10:   w_loadNk = 4'd8;
            default: w_loadNk = 4'd0;
        endcase
        w_lenOk    = (i_key_len != 2'b11) && (w_loadNk <= MAX_NK_W);
        w_accept   = i_key_valid && o_key_ready && !i_rst;
        w_load     = w_accept && w_lenOk;
        w_genWrite = (r_state == GEN) && !i_rst;
    end

    // Next schedule word. r_pos tracks i mod Nk so no divider is needed. The single
    // SubWord sees either RotWord(w[i-1]) at the start of each Nk group or plain
    // w[i-1] for the extra AES-256 substitution at position 4. The round constant
    // lands in the first (most significant) byte of the word.
    always_comb begin
        w_prev    = r_w[r_idx - IDX_W'(1)];
        w_back    = r_w[r_idx - IDX_W'(r_nk)];
        w_subIn   = (r_pos == 4'd0) ? rotWord(w_prev) : w_prev;
        w_subOut  = subWord(w_subIn);
        w_newWord = w_back ^ w_prev;
        if (r_pos == 4'd0) begin
            w_newWord = w_back ^ w_subOut ^ {rcon(r_rconIdx), 24'h0};
        end else if (r_nk == 4'd8 && r_pos == 4'd4) begin
            w_newWord = w_back ^ w_subOut;
        end
    end

    // Word buffer: the key words land in one cycle on accept, then one generated
    // word per GEN cycle. It is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) < w_loadNk) begin
                    r_w[j] <= i_key[32*j +: 32];
                end
            end
        end else if (w_genWrite) begin
            r_w[r_idx] <= w_newWord;
        end
    end

    // Control FSM with registered status outputs. round_avail climbs each time
    // the last word of a round is written, so reads can follow the generator
    // closely. key_ready returns together with sched_valid so the next key can be
    // accepted back-to-back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_nk          <= 4'd0;
            r_pos         <= 4'd0;
            r_rconIdx     <= 4'd0;
            r_idx         <= '0;
            r_lastIdx     <= '0;
            o_key_ready   <= 1'b1;
            o_cfg_err     <= 1'b0;
            o_busy        <= 1'b0;
            o_sched_valid <= 1'b0;
            o_round_avail <= 4'd0;
        end else begin
            o_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        o_sched_valid <= 1'b0;
                        o_round_avail <= 4'd0;
                        if (w_lenOk) begin
                            r_nk          <= w_loadNk;
                            r_pos         <= 4'd0;
                            r_rconIdx     <= 4'd1;
                            r_idx         <= IDX_W'(w_loadNk);
                            r_lastIdx     <= IDX_W'({w_loadNk + 4'd6, 2'b11});
                            o_round_avail <= w_loadNk >> 2;
                            o_key_ready   <= 1'b0;
                            o_busy        <= 1'b1;
                            r_state       <= GEN;
                        end else begin
                            o_cfg_err <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_pos == r_nk - 4'd1) begin
                        r_pos <= 4'd0;
                    end else begin
                        r_pos <= r_pos + 4'd1;
                    end
                    if (r_pos == 4'd0) begin
                        r_rconIdx <= r_rconIdx + 4'd1;
                    end
                    if (r_idx[1:0] == 2'b11) begin
                        o_round_avail <= 4'(r_idx >> 2) + 4'd1;
                    end
                    if (r_idx == r_lastIdx) begin
                        o_busy        <= 1'b0;
                        o_key_ready   <= 1'b1;
                        o_sched_valid <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered read port. Availability is judged against round_avail as it
    // stands in the request cycle, so a read issued alongside a key accept still
    // sees the previous schedule.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
            o_rd_key   <= '0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                if (i_rd_round >= o_round_avail) begin
                    o_rd_err <= 1'b1;
                    o_rd_key <= '0;
                end else begin
                    o_rd_err <= 1'b0;
                    o_rd_key <= {r_w[IDX_W'({i_rd_round, 2'd3})], r_w[IDX_W'({i_rd_round, 2'd2})],
                                 r_w[IDX_W'({i_rd_round, 2'd1})], r_w[IDX_W'({i_rd_round, 2'd0})]};
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq
// Directed bench for aes_key_sched_seq using the FIPS-197 key expansion examples.
// Read requests push their expected result into a scoreboard queue; an independent
// monitor pops and compares whenever the DUT presents o_rd_valid. Status outputs are
// compared directly at known cycle offsets from the key accept.
module tb_aes_key_sched_seq;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] mask;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_key_valid;
    logic         o_key_ready;
    logic [255:0] i_key;
    logic [1:0]   i_key_len;
    logic         o_cfg_err;
    logic         o_busy;
    logic         o_sched_valid;
    logic [3:0]   o_round_avail;
    logic         i_rd_en;
    logic [3:0]   i_rd_round;
    logic         o_rd_valid;
    logic [127:0] o_rd_key;
    logic         o_rd_err;

    exp_t  expQ[$];
    string nameQ[$];
    exp_t  monEntry;
    string monName;
    int    testsRun    = 0;
    int    testsFailed = 0;
    int    cyc         = 0;

    localparam logic [255:0] KEY128 = {128'hdeadbeef_deadbeef_deadbeef_deadbeef,
                                       32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [255:0] KEY192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                       32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
    localparam logic [255:0] KEY256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                       32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

    localparam logic [127:0] R128_0  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [127:0] R128_1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam logic [127:0] R128_10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] W51_TOP = {32'h01002202, 96'h0};
    localparam logic [127:0] R256_0  = {32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
    localparam logic [127:0] R256_1  = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07};
    localparam logic [127:0] R256_14 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};
    localparam logic [127:0] ALL     = {128{1'b1}};
    localparam logic [127:0] TOPWORD = {32'hffffffff, 96'h0};

    aes_key_sched_seq #(.MAX_NK(8)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_key_valid   (i_key_valid),
        .o_key_ready   (o_key_ready),
        .i_key         (i_key),
        .i_key_len     (i_key_len),
        .o_cfg_err     (o_cfg_err),
        .o_busy        (o_busy),
        .o_sched_valid (o_sched_valid),
        .o_round_avail (o_round_avail),
        .i_rd_en       (i_rd_en),
        .i_rd_round    (i_rd_round),
        .o_rd_valid    (o_rd_valid),
        .o_rd_key      (o_rd_key),
        .o_rd_err      (o_rd_err)
    );

    // 10-unit clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Present a key; the following nextCycle crosses the accept edge and lands in t0+1
    task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len);
        i_key       = key;
        i_key_len   = len;
        i_key_valid = 1'b1;
        cyc         = 0;
    endtask

    // Issue a one-cycle read and queue its expected response for the monitor
    task automatic issueRead(input logic [3:0] round, input logic [127:0] key,
                             input logic [127:0] mask, input logic err, input string name);
        exp_t e;
        e.key  = key;
        e.mask = mask;
        e.err  = err;
        expQ.push_back(e);
        nameQ.push_back(name);
        i_rd_en    = 1'b1;
        i_rd_round = round;
        nextCycle();
        i_rd_en = 1'b0;
    endtask

    // Step until sched_valid rises (bounded) and check the cycle offset from t0
    task automatic waitSched(input int expK, input string name);
        int guard = 0;
        while (!o_sched_valid && guard < 200) begin
            nextCycle();
            guard++;
        end
        checkOutput(name, 32'(cyc), 32'(expK));
    endtask

    // Scoreboard monitor: every presented read result must match the oldest expectation
    always @(negedge clk) begin
        if (o_rd_valid) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_read got key=%h err=%b want no rd_valid", o_rd_key, o_rd_err);
            end else begin
                monEntry = expQ.pop_front();
                monName  = nameQ.pop_front();
                if (((o_rd_key & monEntry.mask) !== (monEntry.key & monEntry.mask)) ||
                    (o_rd_err !== monEntry.err)) begin
                    testsFailed++;
                    $display("[TB] FAIL %s got key=%h err=%b want key=%h err=%b", monName,
                             o_rd_key & monEntry.mask, o_rd_err, monEntry.key & monEntry.mask, monEntry.err);
                end
            end
        end
    end

    // Hard stop in case the stimulus process stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        i_rst       = 1'b1;
        i_key_valid = 1'b0;
        i_key       = '0;
        i_key_len   = 2'b00;
        i_rd_en     = 1'b1;
        i_rd_round  = 4'd0;
        repeat (3) nextCycle();
        i_rd_en = 1'b0;
        i_rst   = 1'b0;
        checkOutput("reset_key_ready", 32'(o_key_ready), 32'd1);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_sched_valid", 32'(o_sched_valid), 32'd0);
        checkOutput("reset_round_avail", 32'(o_round_avail), 32'd0);
        checkOutput("reset_cfg_err", 32'(o_cfg_err), 32'd0);
        checkOutput("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        nextCycle();
        issueRead(4'd0, 128'h0, ALL, 1'b1, "read_before_key");

        // AES-128: load, early reads during GEN, sched_valid timing
        applyStimulus(KEY128, 2'b00);
        nextCycle();
        i_key_valid = 1'b0;
        checkOutput("aes128_avail_t1", 32'(o_round_avail), 32'd1);
        checkOutput("aes128_busy_t1", 32'(o_busy), 32'd1);
        checkOutput("aes128_ready_t1", 32'(o_key_ready), 32'd0);
        issueRead(4'd0, R128_0, ALL, 1'b0, "aes128_r0_t1");
        issueRead(4'd1, 128'h0, ALL, 1'b1, "aes128_r1_t2_err");
        waitSched(41, "aes128_sched_cycle");
        checkOutput("aes128_avail_done", 32'(o_round_avail), 32'd11);
        checkOutput("aes128_busy_done", 32'(o_busy), 32'd0);
        checkOutput("aes128_ready_done", 32'(o_key_ready), 32'd1);

        // Back-to-back AES-192 accept, with a same-cycle read of the old schedule;
        // key_valid is then held through part of GEN and must not restart generation
        applyStimulus(KEY192, 2'b01);
        issueRead(4'd10, R128_10, ALL, 1'b0, "aes128_r10_at_accept");
        checkOutput("aes192_sched_dropped", 32'(o_sched_valid), 32'd0);
        checkOutput("aes192_avail_t1", 32'(o_round_avail), 32'd1);
        checkOutput("aes192_busy_t1", 32'(o_busy), 32'd1);
        repeat (20) nextCycle();
        i_key_valid = 1'b0;
        waitSched(47, "aes192_sched_cycle");
        checkOutput("aes192_avail_done", 32'(o_round_avail), 32'd13);
        issueRead(4'd12, W51_TOP, TOPWORD, 1'b0, "aes192_w51");
        issueRead(4'd13, 128'h0, ALL, 1'b1, "aes192_r13_err");

        // AES-256: two rounds available straight after load
        applyStimulus(KEY256, 2'b10);
        nextCycle();
        i_key_valid = 1'b0;
        checkOutput("aes256_avail_t1", 32'(o_round_avail), 32'd2);
        issueRead(4'd1, R256_1, ALL, 1'b0, "aes256_r1_t1");
        issueRead(4'd2, 128'h0, ALL, 1'b1, "aes256_r2_t2_err");
        waitSched(53, "aes256_sched_cycle");
        checkOutput("aes256_avail_done", 32'(o_round_avail), 32'd15);
        issueRead(4'd14, R256_14, ALL, 1'b0, "aes256_r14");
        issueRead(4'd15, 128'h0, ALL, 1'b1, "aes256_r15_err");

        // Illegal key length
        applyStimulus(KEY128, 2'b11);
        nextCycle();
        i_key_valid = 1'b0;
        checkOutput("illegal_cfg_err_t1", 32'(o_cfg_err), 32'd1);
        checkOutput("illegal_busy_t1", 32'(o_busy), 32'd0);
        checkOutput("illegal_sched_valid", 32'(o_sched_valid), 32'd0);
        checkOutput("illegal_avail", 32'(o_round_avail), 32'd0);
        checkOutput("illegal_ready", 32'(o_key_ready), 32'd1);
        nextCycle();
        checkOutput("illegal_cfg_err_t2", 32'(o_cfg_err), 32'd0);
        checkOutput("illegal_busy_t2", 32'(o_busy), 32'd0);
        issueRead(4'd0, 128'h0, ALL, 1'b1, "illegal_r0_err");

        // Reset in the middle of an AES-256 generation
        applyStimulus(KEY256, 2'b10);
        nextCycle();
        i_key_valid = 1'b0;
        issueRead(4'd0, R256_0, ALL, 1'b0, "aes256_r0_before_rst");
        while (cyc < 20) nextCycle();
        i_rst = 1'b1;
        nextCycle();
        checkOutput("midrst_key_ready", 32'(o_key_ready), 32'd1);
        checkOutput("midrst_busy", 32'(o_busy), 32'd0);
        checkOutput("midrst_sched_valid", 32'(o_sched_valid), 32'd0);
        checkOutput("midrst_avail", 32'(o_round_avail), 32'd0);
        checkOutput("midrst_rd_valid", 32'(o_rd_valid), 32'd0);
        checkOutput("midrst_rd_err", 32'(o_rd_err), 32'd0);
        checkOutput("midrst_rd_key_lo", o_rd_key[31:0], 32'd0);
        checkOutput("midrst_rd_key_hi", o_rd_key[127:96], 32'd0);
        i_rst = 1'b0;
        nextCycle();

        // Reload AES-128 after the reset
        applyStimulus(KEY128, 2'b00);
        nextCycle();
        i_key_valid = 1'b0;
        waitSched(41, "reload128_sched_cycle");
        issueRead(4'd10, R128_10, ALL, 1'b0, "reload128_r10");
        issueRead(4'd1, R128_1, ALL, 1'b0, "reload128_r1");
        issueRead(4'd15, 128'h0, ALL, 1'b1, "reload128_r15_err");

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
